// File: rtl/tinyml_cam_bayer_gain.sv
// ---------------------------------------------------------------------------
// tinyml_cam_bayer_gain
// Per-channel white-balance gain for a raw Bayer pixel stream carrying PPC
// pixels per clock. Each pixel takes the gain of its colour site (R, Gr, Gb
// or B), chosen from its row/column parity and the Bayer order. The product is
// rounded, shifted down by GAIN_FRAC and saturated to P_DEPTH bits.
// Gains, pattern and bypass are sampled once per frame, on the falling edge of
// i_vs. Latency is two cycles for data, valid and vs.
//
// Ports
//   i_pclk        clock, rising edge
//   i_srst        synchronous active-high reset
//   i_vs          frame sync, falling edge = frame boundary
//   i_valid       qualifies i_data
//   i_data        PPC lanes of P_DEPTH bits, lane 0 = leftmost pixel (LSBs)
//   i_gain_*      unsigned gains, GAIN_FRAC fraction bits
//   i_pattern     0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
//   i_bypass      pass pixels through unmodified
//   o_vs/o_valid  i_vs/i_valid delayed by two cycles
//   o_data        gained pixels, held while o_valid = 0
//   o_sat_cnt     clipped-pixel count of the previous frame (sticks at 0xFFFF)
// ---------------------------------------------------------------------------
module tinyml_cam_bayer_gain #(
    parameter int P_DEPTH     = 10,
    parameter int PPC         = 4,
    parameter int FRAME_WIDTH = 640,
    parameter int GAIN_W      = 8,
    parameter int GAIN_FRAC   = 6
) (
    input  logic                   i_pclk,
    input  logic                   i_srst,
    input  logic                   i_vs,
    input  logic                   i_valid,
    input  logic [P_DEPTH*PPC-1:0] i_data,
    input  logic [GAIN_W-1:0]      i_gain_r,
    input  logic [GAIN_W-1:0]      i_gain_gr,
    input  logic [GAIN_W-1:0]      i_gain_gb,
    input  logic [GAIN_W-1:0]      i_gain_b,
    input  logic [1:0]             i_pattern,
    input  logic                   i_bypass,
    output logic                   o_vs,
    output logic                   o_valid,
    output logic [P_DEPTH*PPC-1:0] o_data,
    output logic [15:0]            o_sat_cnt
);

    localparam int PW    = P_DEPTH * PPC;
    localparam int BEATS = FRAME_WIDTH / PPC;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MW    = P_DEPTH + GAIN_W;

    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(2 ** GAIN_FRAC);
    localparam logic [MW:0]       RND_HALF = (MW + 1)'(2 ** (GAIN_FRAC - 1));
    localparam logic [MW:0]       PIX_MAX  = (MW + 1)'(2 ** P_DEPTH - 1);

    // Round to nearest and drop the fraction; one spare bit keeps the
    // rounding add from wrapping at the top of the product range.
    function automatic logic [MW:0] round_shift(input logic [MW-1:0] prod);
        return ({1'b0, prod} + RND_HALF) >> GAIN_FRAC;
    endfunction

    function automatic logic is_clip(input logic [MW-1:0] prod);
        return round_shift(prod) > PIX_MAX;
    endfunction

    function automatic logic [P_DEPTH-1:0] round_sat(input logic [MW-1:0] prod);
        logic [MW:0] q;
        q = round_shift(prod);
        return (q > PIX_MAX) ? {P_DEPTH{1'b1}} : q[P_DEPTH-1:0];
    endfunction

    logic              r_vs_d;
    logic              w_boundary;
    logic [GAIN_W-1:0] r_gain_r, r_gain_gr, r_gain_gb, r_gain_b;
    logic [1:0]        r_pattern;
    logic              r_bypass;
    logic [GAIN_W-1:0] w_gain [4];
    logic [1:0]        w_pattern;
    logic              w_bypass;
    logic [BW-1:0]     r_beat, w_beat;
    logic              r_row, w_row, w_last;
    logic [1:0]        w_chan [PPC];
    logic [MW-1:0]     w_prod [PPC];

    logic [MW-1:0]     r_prod_p1 [PPC];
    logic [PW-1:0]     r_pix_p1;
    logic              r_byp_p1, r_vld_p1, r_vs_p1;

    logic [PW-1:0]     r_data_p2;
    logic              r_vld_p2, r_vs_p2;
    logic [15:0]       r_sat_acc, r_sat_cnt;
    logic [PW-1:0]     w_res;
    logic [15:0]       w_clips;
    logic [16:0]       w_sum;
    logic [15:0]       w_sat_next;

    // A beat on the boundary cycle is already part of the new frame: it sees
    // the freshly sampled settings and starts at beat 0 of row 0.
    always_comb begin
        w_boundary = r_vs_d & ~i_vs;
        if (w_boundary) begin
            w_gain[0] = i_gain_r;
            w_gain[1] = i_gain_gr;
            w_gain[2] = i_gain_gb;
            w_gain[3] = i_gain_b;
            w_pattern = i_pattern;
            w_bypass  = i_bypass;
            w_beat    = '0;
            w_row     = 1'b0;
        end else begin
            w_gain[0] = r_gain_r;
            w_gain[1] = r_gain_gr;
            w_gain[2] = r_gain_gb;
            w_gain[3] = r_gain_b;
            w_pattern = r_pattern;
            w_bypass  = r_bypass;
            w_beat    = r_beat;
            w_row     = r_row;
        end
        w_last = (w_beat == BW'(BEATS - 1));
    end

    // Channel index is {row, col} in RGGB terms (0 R, 1 Gr, 2 Gb, 3 B); every
    // other Bayer order is that tile XOR-ed by the pattern code.
    always_comb begin
        for (int k = 0; k < PPC; k++) begin
            w_chan[k] = {w_row, (PPC == 1) ? w_beat[0] : k[0]} ^ w_pattern;
            w_prod[k] = MW'(i_data[k*P_DEPTH +: P_DEPTH]) * MW'(w_gain[w_chan[k]]);
        end
    end

    // ---- stage 1: products ----
    always_ff @(posedge i_pclk) begin
        r_pix_p1 <= i_data;
        r_byp_p1 <= w_bypass;
        for (int k = 0; k < PPC; k++) begin
            r_prod_p1[k] <= w_prod[k];
        end
    end

    // ---- stage 2: round / saturate and clip counting ----
    always_comb begin
        w_res   = '0;
        w_clips = '0;
        for (int k = 0; k < PPC; k++) begin
            w_res[k*P_DEPTH +: P_DEPTH] = r_byp_p1 ? r_pix_p1[k*P_DEPTH +: P_DEPTH]
                                                   : round_sat(r_prod_p1[k]);
            if (r_vld_p1 && !r_byp_p1 && is_clip(r_prod_p1[k])) begin
                w_clips = w_clips + 16'd1;
            end
        end
        w_sum      = {1'b0, r_sat_acc} + {1'b0, w_clips};
        w_sat_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_ff @(posedge i_pclk) begin
        if (i_srst) begin
            r_vs_d    <= 1'b0;
            r_beat    <= '0;
            r_row     <= 1'b0;
            r_gain_r  <= UNITY;
            r_gain_gr <= UNITY;
            r_gain_gb <= UNITY;
            r_gain_b  <= UNITY;
            r_pattern <= 2'd0;
            r_bypass  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vs_p1   <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vs_p2   <= 1'b0;
            r_data_p2 <= '0;
            r_sat_acc <= '0;
            r_sat_cnt <= '0;
        end else begin
            r_vs_d <= i_vs;
            if (i_valid) begin
                r_beat <= w_last ? '0 : w_beat + BW'(1);
                r_row  <= w_row ^ w_last;
            end else begin
                r_beat <= w_beat;
                r_row  <= w_row;
            end
            if (w_boundary) begin
                r_gain_r  <= i_gain_r;
                r_gain_gr <= i_gain_gr;
                r_gain_gb <= i_gain_gb;
                r_gain_b  <= i_gain_b;
                r_pattern <= i_pattern;
                r_bypass  <= i_bypass;
            end
            r_vld_p1 <= i_valid;
            r_vs_p1  <= i_vs;
            r_vld_p2 <= r_vld_p1;
            r_vs_p2  <= r_vs_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_res;
            end
            // Beats still in stage 1 on the boundary cycle belong to the
            // frame that is ending, so they are folded into the copied total.
            if (w_boundary) begin
                r_sat_cnt <= w_sat_next;
                r_sat_acc <= '0;
            end else begin
                r_sat_acc <= w_sat_next;
            end
        end
    end

    assign o_vs      = r_vs_p2;
    assign o_valid   = r_vld_p2;
    assign o_data    = r_data_p2;
    assign o_sat_cnt = r_sat_cnt;

endmodule
